mem_bus_arbiter: RTL

Shares one external single-ported memory bus between the pipeline's instruction fetch port (IF stage) and data port (MEM stage). For each pipeline step it runs the pending data access first and the instruction fetch second, each as a req/ack transfer on the bus. It holds the whole pipeline through `stall` until both transfers complete. It sits between `pipeline_CPU`'s ROM/data memory ports and a unified off-core memory with variable wait states.

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/arb_timeout_cnt.sv | 31 +++
 rtl/mem_bus_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and constants for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int ArbStateWidth = 2;
  localparam int CntWidth      = 8;
  localparam int SelWidth      = 4;

  localparam logic [SelWidth-1:0] FetchSel = 4'hF;

  typedef enum logic [ArbStateWidth-1:0] {
    ArbIdle    = 2'd0,
    ArbData    = 2'd1,
    ArbInst    = 2'd2,
    ArbRelease = 2'd3
  } arb_state_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Wait-cycle counter for one bus transfer; flags when the transfer reaches Timeout cycles.
module arb_timeout_cnt
  import mem_bus_arbiter_pkg::*;
#(
  parameter int Timeout = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CntWidth:0] Limit = (CntWidth + 1)'(Timeout);

  logic [CntWidth-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the cycle whose un-acked edge would bring the count to Timeout.
  assign expired = en && (({1'b0, cnt} + 1'b1) == Limit);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises the pipeline's data access and instruction fetch onto one req/ack memory bus.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int Timeout   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_ce,
  input  logic [AddrWidth-1:0] if_addr,
  output logic [DataWidth-1:0] if_inst,
  input  logic                 mem_re,
  input  logic                 mem_we,
  input  logic [AddrWidth-1:0] mem_addr,
  input  logic [SelWidth-1:0]  mem_byte_slct,
  input  logic [DataWidth-1:0] mem_wdata,
  output logic [DataWidth-1:0] mem_rdata,
  output logic                 stall,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [AddrWidth-1:0] bus_addr,
  output logic [SelWidth-1:0]  bus_sel,
  output logic [DataWidth-1:0] bus_wdata,
  input  logic [DataWidth-1:0] bus_rdata,
  input  logic                 bus_ack,
  output logic                 bus_err
);

  arb_state_t state, next_state;

  logic                 lat_if_ce;
  logic [AddrWidth-1:0] lat_if_addr;
  logic [DataWidth-1:0] data_buf, inst_buf;
  logic                 busy, done, expired;

  assign busy = (state == ArbData) || (state == ArbInst);
  assign done = busy && (bus_ack || expired);

  arb_timeout_cnt #(.Timeout(Timeout)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy || done),
    .en      (busy && !bus_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ArbIdle;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      ArbIdle: begin
        stall = if_ce || mem_re || mem_we;
        if (mem_re || mem_we) next_state = ArbData;
        else if (if_ce)       next_state = ArbInst;
      end
      ArbData: begin
        stall = 1'b1;
        if (done) next_state = lat_if_ce ? ArbInst : ArbRelease;
      end
      ArbInst: begin
        stall = 1'b1;
        if (done) next_state = ArbRelease;
      end
      default: next_state = ArbIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) lat_if_ce <= 1'b0;
    else if (state == ArbIdle) lat_if_ce <= if_ce;
  end

  always_ff @(posedge clk) begin
    if (state == ArbIdle) lat_if_addr <= if_addr;
  end

  // Bus fields are loaded on entry to a transfer and held until its ack/abort edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_sel   <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        ArbIdle: begin
          if (mem_re || mem_we) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_sel   <= mem_byte_slct;
            bus_wdata <= mem_wdata;
          end else if (if_ce) begin
            bus_req  <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= if_addr;
            bus_sel  <= FetchSel;
          end
        end
        ArbData: begin
          if (done) begin
            if (lat_if_ce) begin
              bus_we   <= 1'b0;
              bus_addr <= lat_if_addr;
              bus_sel  <= FetchSel;
            end else begin
              bus_req <= 1'b0;
            end
          end
        end
        ArbInst: begin
          if (done) bus_req <= 1'b0;
        end
        default: bus_req <= 1'b0;
      endcase
    end
  end

  // Writes and aborted transfers leave zero in the target buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_buf <= '0;
      inst_buf <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (state == ArbData && done)
        data_buf <= (bus_ack && !bus_we) ? bus_rdata : '0;
      if (state == ArbInst && done)
        inst_buf <= bus_ack ? bus_rdata : '0;
      if (expired)
        bus_err <= 1'b1;
    end
  end

  assign if_inst   = inst_buf;
  assign mem_rdata = data_buf;

endmodule
